seg_value_formatter: RTL and testbench

SEG_VALUE_FORMATTER -- requirements
Module: seg_value_formatter

---
 rtl/seg_value_formatter.sv | 137 +++++++++++++
 tb/tb_seg_value_formatter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_value_formatter.sv
// Formats an 8-bit value as two active-low 7-segment digits, either hex nibbles
// or decimal 00-99 via an iterative double-dabble, with overflow dash display.
module seg_value_formatter (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       mode,
  input  logic       load,
  output logic [6:0] display_1,
  output logic [6:0] display_2,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int unsigned VAL_W = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t             state;
  logic [VAL_W-1:0]   val_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [BCD_W-1:0]   bcd_next_c;
  logic [SEG_W-1:0]   dec_d1_c;
  logic [SEG_W-1:0]   dec_d2_c;
  logic               dec_ovf_c;

  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                               input logic in_bit);
    logic [BCD_W-1:0] a;
    a = b;
    for (int n = 0; n < 3; n++) begin
      if (a[n*4 +: 4] >= 4'd5) a[n*4 +: 4] = a[n*4 +: 4] + 4'd3;
    end
    dd_step = {a[BCD_W-2:0], in_bit};
  endfunction

  // Decimal digit patterns derived from the accumulator after the current shift.
  always_comb begin
    bcd_next_c = dd_step(bcd_q, val_q[VAL_W-1]);
    dec_ovf_c  = (bcd_next_c[11:8] != 4'd0);
    dec_d1_c   = seg7(bcd_next_c[3:0]);
    dec_d2_c   = (bcd_next_c[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_next_c[7:4]);
    if (dec_ovf_c) begin
      dec_d1_c = SEG_DASH;
      dec_d2_c = SEG_DASH;
    end
  end

  // Displays, done and overflow are written on entry to ENCODE so that done
  // falls inside the busy window; ENCODE itself just returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      val_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      display_1 <= SEG_BLANK;
      display_2 <= SEG_BLANK;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            val_q <= value;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
            if (mode) begin
              state <= SHIFT;
            end else begin
              state     <= ENCODE;
              display_2 <= seg7(value[7:4]);
              display_1 <= seg7(value[3:0]);
              overflow  <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          val_q <= {val_q[VAL_W-2:0], 1'b0};
          bcd_q <= bcd_next_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(VAL_W - 1)) begin
            state     <= ENCODE;
            display_1 <= dec_d1_c;
            display_2 <= dec_d2_c;
            overflow  <= dec_ovf_c;
            done      <= 1'b1;
          end
        end
        ENCODE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_value_formatter.sv
// Directed bench for seg_value_formatter: hex/decimal formatting, blanking,
// overflow, busy rejection, mid-conversion reset and held-load restarts.
module tb_seg_value_formatter;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       mode;
  logic       load;
  logic [6:0] display_1;
  logic [6:0] display_2;
  logic       busy;
  logic       done;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  seg_value_formatter dut (
    .clock     (clock),
    .reset     (reset),
    .value     (value),
    .mode      (mode),
    .load      (load),
    .display_1 (display_1),
    .display_2 (display_2),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // Pulse load for one edge, then watch a fixed window of cycles at negedges.
  task automatic run_conv(input logic [7:0] v, input logic m,
                          output int busy_cyc, output int done_cnt, output int done_at,
                          output logic [6:0] d1, output logic [6:0] d2, output logic ovf);
    busy_cyc = 0; done_cnt = 0; done_at = -1; d1 = 'x; d2 = 'x; ovf = 1'bx;
    @(negedge clock);
    value = v; mode = m; load = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 0) load = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; done_at = i + 1; d1 = display_1; d2 = display_2; ovf = overflow;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = 8'h00; mode = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++; if (display_1 !== 7'h7F) begin failures++; $display("FAIL reset_d1 got=%h exp=7f", display_1); end
    checks++; if (display_2 !== 7'h7F) begin failures++; $display("FAIL reset_d2 got=%h exp=7f", display_2); end
    checks++; if ({busy, done, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, overflow}); end
  endtask

  task automatic test_hex();
    int bc, dc, da; logic [6:0] d1, d2; logic ov;
    run_conv(8'h3C, 1'b0, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h30) begin failures++; $display("FAIL hex_3c_d2 got=%h exp=30", d2); end
    checks++; if (d1 !== 7'h46) begin failures++; $display("FAIL hex_3c_d1 got=%h exp=46", d1); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL hex_3c_ovf got=%b exp=0", ov); end
    checks++; if (bc !== 1) begin failures++; $display("FAIL hex_busy_cycles got=%0d exp=1", bc); end
    checks++; if (dc !== 1 || da !== 1) begin failures++; $display("FAIL hex_done got_cnt=%0d got_at=%0d exp=1/1", dc, da); end
    checks++; if (display_2 !== 7'h30 || display_1 !== 7'h46) begin failures++; $display("FAIL hex_hold got=%h/%h exp=30/46", display_2, display_1); end
  endtask

  task automatic test_decimal();
    int bc, dc, da; logic [6:0] d1, d2; logic ov;
    run_conv(8'd57, 1'b1, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h12 || d1 !== 7'h78) begin failures++; $display("FAIL dec_57 got=%h/%h exp=12/78", d2, d1); end
    checks++; if (bc !== 9) begin failures++; $display("FAIL dec_busy_cycles got=%0d exp=9", bc); end
    checks++; if (dc !== 1 || da !== 9) begin failures++; $display("FAIL dec_done got_cnt=%0d got_at=%0d exp=1/9", dc, da); end
    run_conv(8'd86, 1'b1, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h00 || d1 !== 7'h02) begin failures++; $display("FAIL dec_86 got=%h/%h exp=00/02", d2, d1); end
  endtask

  task automatic test_blanking();
    int bc, dc, da; logic [6:0] d1, d2; logic ov;
    run_conv(8'd7, 1'b1, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h7F || d1 !== 7'h78) begin failures++; $display("FAIL blank_7 got=%h/%h exp=7f/78", d2, d1); end
    run_conv(8'd0, 1'b1, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h7F || d1 !== 7'h40) begin failures++; $display("FAIL blank_0 got=%h/%h exp=7f/40", d2, d1); end
    run_conv(8'd99, 1'b1, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h10 || d1 !== 7'h10 || ov !== 1'b0) begin failures++; $display("FAIL dec_99 got=%h/%h ovf=%b exp=10/10 ovf=0", d2, d1, ov); end
  endtask

  task automatic test_overflow();
    int bc, dc, da; logic [6:0] d1, d2; logic ov;
    run_conv(8'd200, 1'b1, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h3F || d1 !== 7'h3F) begin failures++; $display("FAIL ovf_200 got=%h/%h exp=3f/3f", d2, d1); end
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_200_flag got=%b exp=1", ov); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%b exp=1", overflow); end
    run_conv(8'hA5, 1'b0, bc, dc, da, d1, d2, ov);
    checks++; if (d2 !== 7'h08 || d1 !== 7'h12) begin failures++; $display("FAIL hex_a5 got=%h/%h exp=08/12", d2, d1); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ov); end
  endtask

  task automatic test_busy_reject();
    int bc = 0, dc = 0;
    @(negedge clock);
    value = 8'd99; mode = 1'b1; load = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy) bc++;
      if (done) begin
        dc++;
        checks++; if (display_2 !== 7'h10 || display_1 !== 7'h10) begin failures++; $display("FAIL reject_result got=%h/%h exp=10/10", display_2, display_1); end
      end
      load = (i >= 1 && i <= 3);
      if (load) value = 8'd11;
    end
    checks++; if (dc !== 1) begin failures++; $display("FAIL reject_done_count got=%0d exp=1", dc); end
    checks++; if (bc !== 9) begin failures++; $display("FAIL reject_busy_cycles got=%0d exp=9", bc); end
  endtask

  task automatic test_mid_reset();
    int dc = 0, bc, dn, da; logic [6:0] d1, d2; logic ov;
    @(negedge clock);
    value = 8'd42; mode = 1'b1; load = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      load = 1'b0;
      if (done) dc++;
      if (i == 3) reset = 1'b1;
      if (i == 4) begin
        reset = 1'b0;
        checks++; if (display_2 !== 7'h7F || display_1 !== 7'h7F) begin failures++; $display("FAIL midreset_disp got=%h/%h exp=7f/7f", display_2, display_1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      end
    end
    checks++; if (dc !== 0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", dc); end
    checks++; if (display_2 !== 7'h7F || display_1 !== 7'h7F) begin failures++; $display("FAIL midreset_hold got=%h/%h exp=7f/7f", display_2, display_1); end
    run_conv(8'hFF, 1'b0, bc, dn, da, d1, d2, ov);
    checks++; if (d2 !== 7'h0E || d1 !== 7'h0E) begin failures++; $display("FAIL after_reset_ff got=%h/%h exp=0e/0e", d2, d1); end
  endtask

  task automatic test_back_to_back();
    int dc = 0, idle_cnt = 0;
    @(negedge clock);
    value = 8'h12; mode = 1'b0; load = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) dc++;
    end
    checks++; if (dc !== 5) begin failures++; $display("FAIL b2b_hex_dones got=%0d exp=5", dc); end
    checks++; if (display_2 !== 7'h79 || display_1 !== 7'h24) begin failures++; $display("FAIL b2b_hex_disp got=%h/%h exp=79/24", display_2, display_1); end
    load = 1'b0;
    repeat (3) @(negedge clock);
    dc = 0;
    value = 8'd34; mode = 1'b1; load = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) dc++;
      if (!busy) idle_cnt++;
    end
    load = 1'b0;
    checks++; if (dc !== 2) begin failures++; $display("FAIL b2b_dec_dones got=%0d exp=2", dc); end
    checks++; if (idle_cnt !== 2) begin failures++; $display("FAIL b2b_dec_idle got=%0d exp=2", idle_cnt); end
    checks++; if (display_2 !== 7'h30 || display_1 !== 7'h19) begin failures++; $display("FAIL b2b_dec_disp got=%h/%h exp=30/19", display_2, display_1); end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_blanking();
    test_overflow();
    test_busy_reject();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
